// File: rtl/mem_pkg.sv
// Shared definitions for the latency-modelling memory responder: FSM encoding,
// default miss latency and small request-decoding helpers.
package mem_pkg;

  localparam int unsigned DefaultLatency = 4;
  localparam int unsigned CntW           = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  // Both strobes at once, or an odd byte address, cannot be serviced.
  function automatic logic is_illegal(input logic rd, input logic wr, input logic addr_lsb);
    return (rd & wr) | addr_lsb;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Backing store: single-port word array with synchronous write, combinational
// read and no reset, so contents survive a responder reset.
module mem_responder_array #(
  parameter int unsigned Width = 16,
  parameter int unsigned Words = 1024,
  localparam int unsigned IdxW = $clog2(Words)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IdxW-1:0]  addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_latency_responder.sv
// Memory responder modelling a fixed miss latency, fronted by a one-entry
// last-read buffer that completes matching reads in a single cycle.
module mem_latency_responder
  import mem_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned LATENCY   = DefaultLatency,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Addr,
  input  logic [N-1:0] DataIn,
  input  logic         Rd,
  input  logic         Wr,
  output logic [N-1:0] DataOut,
  output logic         Done,
  output logic         Stall,
  output logic         CacheHit,
  output logic         err
);

  localparam int unsigned IdxW    = $clog2(MEM_WORDS);
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Request captured at acceptance; inputs are ignored afterwards.
  logic            req_rd_q, req_rd_d;
  logic            req_illegal_q, req_illegal_d;
  logic            req_hit_q, req_hit_d;
  logic [IdxW-1:0] req_idx_q, req_idx_d;
  logic [N-1:0]    req_data_q, req_data_d;

  logic            buf_valid_q, buf_valid_d;
  logic [IdxW-1:0] buf_idx_q, buf_idx_d;
  logic [N-1:0]    buf_data_q, buf_data_d;

  logic [IdxW-1:0] in_idx;
  logic            in_illegal;
  logic            in_hit;
  logic            arr_we;
  logic [N-1:0]    arr_rdata;
  logic            unused_addr;

  assign in_idx      = Addr[IdxW:1];
  assign unused_addr = ^Addr[N-1:IdxW+1];
  assign in_illegal  = is_illegal(Rd, Wr, Addr[0]);
  assign in_hit      = Rd & ~Wr & ~in_illegal & buf_valid_q & (buf_idx_q == in_idx);

  // Next-state and request capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_rd_d      = req_rd_q;
    req_illegal_d = req_illegal_q;
    req_hit_d     = req_hit_q;
    req_idx_d     = req_idx_q;
    req_data_d    = req_data_q;
    unique case (state_q)
      StIdle: begin
        if (Rd | Wr) begin
          req_rd_d      = Rd & ~Wr;
          req_illegal_d = in_illegal;
          req_hit_d     = in_hit;
          req_idx_d     = in_idx;
          req_data_d    = DataIn;
          if (in_illegal || in_hit) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = CntLoad;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_d == '0) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Buffer maintenance happens only as a legal miss or write completes.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
    buf_data_d  = buf_data_q;
    if (state_q == StResp && !req_illegal_q) begin
      if (req_rd_q && !req_hit_q) begin
        buf_valid_d = 1'b1;
        buf_idx_d   = req_idx_q;
        buf_data_d  = arr_rdata;
      end else if (!req_rd_q && buf_valid_q && (buf_idx_q == req_idx_q)) begin
        buf_data_d = req_data_q;
      end
    end
  end

  // Gated by rst so a request cut short by reset never reaches the array.
  assign arr_we = rst & (state_q == StResp) & ~req_rd_q & ~req_illegal_q;

  always_comb begin
    Done     = 1'b0;
    Stall    = (state_q == StBusy);
    CacheHit = 1'b0;
    err      = 1'b0;
    DataOut  = '0;
    if (state_q == StResp) begin
      Done = 1'b1;
      if (req_illegal_q) begin
        err = 1'b1;
      end else if (req_hit_q) begin
        CacheHit = 1'b1;
        DataOut  = buf_data_q;
      end else if (req_rd_q) begin
        DataOut = arr_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      req_rd_q      <= 1'b0;
      req_illegal_q <= 1'b0;
      req_hit_q     <= 1'b0;
      req_idx_q     <= '0;
      req_data_q    <= '0;
      buf_valid_q   <= 1'b0;
      buf_idx_q     <= '0;
      buf_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_rd_q      <= req_rd_d;
      req_illegal_q <= req_illegal_d;
      req_hit_q     <= req_hit_d;
      req_idx_q     <= req_idx_d;
      req_data_q    <= req_data_d;
      buf_valid_q   <= buf_valid_d;
      buf_idx_q     <= buf_idx_d;
      buf_data_q    <= buf_data_d;
    end
  end

  mem_responder_array #(
    .Width (N),
    .Words (MEM_WORDS)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .addr_i  (req_idx_q),
    .wdata_i (req_data_q),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed bench for mem_latency_responder: miss, hit, write, illegal, reset
// mid-request and held-request sequences with hand-computed expectations.
module tb_mem_latency_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_latency_responder dut (
    .clk      (clk),
    .rst      (rst),
    .Addr     (Addr),
    .DataIn   (DataIn),
    .Rd       (Rd),
    .Wr       (Wr),
    .DataOut  (DataOut),
    .Done     (Done),
    .Stall    (Stall),
    .CacheHit (CacheHit),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".done"}, {15'd0, Done}, 16'd0);
    chk({tag, ".stall"}, {15'd0, Stall}, 16'd0);
    chk({tag, ".hit"}, {15'd0, CacheHit}, 16'd0);
    chk({tag, ".err"}, {15'd0, err}, 16'd0);
    chk({tag, ".dout"}, DataOut, 16'd0);
  endtask

  initial begin
    dut.u_array.mem_q[10'h010] = 16'hBEEF;
    dut.u_array.mem_q[10'h020] = 16'h5555;
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
    tick();
    tick();
    chk_idle_outs("reset");
    rst = 1'b1;
    tick();

    // Read miss at 0x0020 (word 0x010).
    Rd = 1'b1; Addr = 16'h0020;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("miss.stall.c%0d", c), {15'd0, Stall}, 16'd1);
      chk($sformatf("miss.done.c%0d", c), {15'd0, Done}, 16'd0);
      chk($sformatf("miss.dout.c%0d", c), DataOut, 16'd0);
    end
    tick();
    chk("miss.done", {15'd0, Done}, 16'd1);
    chk("miss.stall", {15'd0, Stall}, 16'd0);
    chk("miss.hit", {15'd0, CacheHit}, 16'd0);
    chk("miss.dout", DataOut, 16'hBEEF);
    Rd = 1'b0;
    tick();
    chk_idle_outs("miss.after");

    // Repeat read hits the buffer.
    Rd = 1'b1; Addr = 16'h0020;
    tick();
    chk("hit.done", {15'd0, Done}, 16'd1);
    chk("hit.hit", {15'd0, CacheHit}, 16'd1);
    chk("hit.stall", {15'd0, Stall}, 16'd0);
    chk("hit.dout", DataOut, 16'hBEEF);
    Rd = 1'b0;
    tick();
    chk_idle_outs("hit.after");

    // Write 0x1234; inputs changed after acceptance must not matter.
    Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h1234;
    tick();
    DataIn = 16'hFFFF; Addr = 16'h0002;
    chk("wr.stall.c1", {15'd0, Stall}, 16'd1);
    tick();
    tick();
    chk("wr.stall.c3", {15'd0, Stall}, 16'd1);
    tick();
    chk("wr.done", {15'd0, Done}, 16'd1);
    chk("wr.stall", {15'd0, Stall}, 16'd0);
    chk("wr.dout", DataOut, 16'd0);
    chk("wr.hit", {15'd0, CacheHit}, 16'd0);
    Wr = 1'b0;
    tick();
    Rd = 1'b1; Addr = 16'h0020;
    tick();
    chk("wrhit.done", {15'd0, Done}, 16'd1);
    chk("wrhit.hit", {15'd0, CacheHit}, 16'd1);
    chk("wrhit.dout", DataOut, 16'h1234);
    Rd = 1'b0;
    tick();

    // Illegal: both strobes.
    Rd = 1'b1; Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h9999;
    tick();
    chk("ill2.done", {15'd0, Done}, 16'd1);
    chk("ill2.err", {15'd0, err}, 16'd1);
    chk("ill2.stall", {15'd0, Stall}, 16'd0);
    chk("ill2.dout", DataOut, 16'd0);
    chk("ill2.hit", {15'd0, CacheHit}, 16'd0);
    Rd = 1'b0; Wr = 1'b0;
    tick();
    chk_idle_outs("ill2.after");

    // Illegal: odd address whose word index matches the buffer.
    Rd = 1'b1; Addr = 16'h0021;
    tick();
    chk("illodd.done", {15'd0, Done}, 16'd1);
    chk("illodd.err", {15'd0, err}, 16'd1);
    chk("illodd.hit", {15'd0, CacheHit}, 16'd0);
    chk("illodd.dout", DataOut, 16'd0);
    Rd = 1'b0;
    tick();
    Rd = 1'b1; Addr = 16'h0020;
    tick();
    chk("postill.hit", {15'd0, CacheHit}, 16'd1);
    chk("postill.dout", DataOut, 16'h1234);
    Rd = 1'b0;
    tick();

    // Reset asserted in cycle 2 of a write to 0x0040.
    Wr = 1'b1; Addr = 16'h0040; DataIn = 16'hAAAA;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid.done", {15'd0, Done}, 16'd0);
    chk("rstmid.stall", {15'd0, Stall}, 16'd0);
    rst = 1'b1; Wr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rstmid.nodone.%0d", c), {15'd0, Done}, 16'd0);
    end
    Rd = 1'b1; Addr = 16'h0040;
    tick();
    chk("rstrd.stall", {15'd0, Stall}, 16'd1);
    tick();
    tick();
    tick();
    chk("rstrd.done", {15'd0, Done}, 16'd1);
    chk("rstrd.hit", {15'd0, CacheHit}, 16'd0);
    chk("rstrd.dout", DataOut, 16'h5555);
    Rd = 1'b0;
    tick();

    // Held read: miss completes at c4, then hits every second cycle.
    Rd = 1'b1; Addr = 16'h0020;
    for (int c = 1; c <= 12; c++) begin
      logic exp_done;
      logic exp_hit;
      tick();
      exp_hit  = (c >= 6) && (c % 2 == 0);
      exp_done = (c == 4) || exp_hit;
      chk($sformatf("held.done.c%0d", c), {15'd0, Done}, {15'd0, exp_done});
      chk($sformatf("held.hit.c%0d", c), {15'd0, CacheHit}, {15'd0, exp_hit});
      chk($sformatf("held.dout.c%0d", c), DataOut, exp_done ? 16'h1234 : 16'h0000);
    end
    Rd = 1'b0;
    tick();
    tick();
    chk_idle_outs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
